// File: rtl/mem_region_mux.sv
// mem_region_mux: region decoder, wait-state sequencer and read-return mux; optional per-region hit counters under MEM_REGION_MUX_PERF_EN
module mem_region_mux #(
  parameter int REGIONS = 4,
  parameter int DATA_W = 32,
  parameter logic [REGIONS*4-1:0] REGION_BASE = {4'hE, 4'h8, 4'h4, 4'h0},
  parameter logic [REGIONS*4-1:0] REGION_WAIT = {4'd3, 4'd1, 4'd0, 4'd0}
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req,
  input  logic [31:0]                address,
  input  logic [DATA_W/8-1:0]        data_we,
  input  logic [DATA_W-1:0]          data_write,
  input  logic [REGIONS*DATA_W-1:0]  rdata_bus,
  output logic [REGIONS-1:0]         cs_n,
  output logic [DATA_W/8-1:0]        we_n,
  output logic [DATA_W-1:0]          data_o,
  output logic [DATA_W-1:0]          data_read,
  output logic                       stall,
  output logic                       err
`ifdef MEM_REGION_MUX_PERF_EN
  ,
  output logic [REGIONS*16-1:0]      hit_count
`endif
);
  localparam int IW = REGIONS > 1 ? $clog2(REGIONS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    hit_w;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] sel_q;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] cur_idx;
  logic          unm_q;
  logic          hit_any;
  logic          active;
  logic          done;
  logic          miss;
  // Address tag decode; scanning downwards lets the lowest matching region win
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_w = '0;
    for (int k = REGIONS - 1; k >= 0; k--)
      if (req && address[31:28] == REGION_BASE[4*k +: 4]) begin
        hit_any = 1'b1;
        hit_idx = IW'(k);
        hit_w = REGION_WAIT[4*k +: 4];
      end
  end
  // Strobes, stall and read-return mux; while in WAIT the latched region governs, not the address
  always_comb begin
    cur_idx = state == WAIT ? idx_q : hit_idx;
    active = reset_n && (state == WAIT || hit_any);
    done = active && (state == WAIT ? cnt == 4'd0 : hit_w == 4'd0);
    miss = reset_n && state == IDLE && req && !hit_any;
    stall = active && !done;
    we_n = done ? ~data_we : '1;
    cs_n = '1;
    for (int k = 0; k < REGIONS; k++)
      cs_n[k] = !(active && cur_idx == IW'(k));
    data_read = '0;
    for (int k = 0; k < REGIONS; k++)
      if (!unm_q && sel_q == IW'(k)) data_read = rdata_bus[DATA_W*k +: DATA_W];
  end
  // Wait-state FSM plus registered read select and unmapped flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      sel_q <= '0;
      unm_q <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= miss;
      if (miss) unm_q <= 1'b1;
      if (done) begin
        sel_q <= cur_idx;
        unm_q <= 1'b0;
        state <= IDLE;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      else if (active) begin
        idx_q <= hit_idx;
        cnt <= hit_w - 4'd1;
        state <= WAIT;
      end
    end
  end
  assign data_o = data_write;
`ifdef MEM_REGION_MUX_PERF_EN
  logic [15:0] hits [REGIONS];
  for (genvar i = 0; i < REGIONS; i++) begin : g_perf
    // Saturating count of completed accesses for this region
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) hits[i] <= '0;
      else if (done && cur_idx == IW'(i) && hits[i] != 16'hFFFF) hits[i] <= hits[i] + 16'd1;
    end
    assign hit_count[16*i +: 16] = hits[i];
  end
`endif
endmodule

// File: tb/tb_mem_region_mux.sv
// tb_mem_region_mux: vector table with a read-return scoreboard plus a reset-during-stall sequence
module tb_mem_region_mux;
  localparam logic [31:0] R0 = 32'hDEADBEEF;
  localparam logic [31:0] R1 = 32'hCAFEF00D;
  localparam logic [31:0] R2 = 32'h0BADC0DE;
  localparam logic [31:0] R3 = 32'hA5A5A5A5;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req = 1'b0;
  logic [31:0] address = '0;
  logic [3:0] data_we = '0;
  logic [31:0] data_write = '0;
  logic [127:0] rdata_bus;
  logic [3:0] cs_n;
  logic [3:0] we_n;
  logic [31:0] data_o;
  logic [31:0] data_read;
  logic stall;
  logic err;
`ifdef MEM_REGION_MUX_PERF_EN
  logic [63:0] hit_count;
`endif
  typedef struct {
    logic req; logic [31:0] addr; logic [3:0] we;
    logic [3:0] cs; logic [3:0] wen; logic st;
    logic [31:0] rd; logic er; int reg_done;
  } vec_t;
  typedef struct { logic [31:0] rd; logic er; } sb_t;
  sb_t sbq[$];
  vec_t v[17];
  int errors = 0;
  int checks = 0;
  int exp_hits[4] = '{0, 0, 0, 0};
  int wlow = 0;
  logic watch = 1'b0;
  assign rdata_bus = {R3, R2, R1, R0};
  mem_region_mux dut (
    .clock(clock), .reset_n(reset_n), .req(req), .address(address),
    .data_we(data_we), .data_write(data_write), .rdata_bus(rdata_bus),
    .cs_n(cs_n), .we_n(we_n), .data_o(data_o), .data_read(data_read),
    .stall(stall), .err(err)
`ifdef MEM_REGION_MUX_PERF_EN
    , .hit_count(hit_count)
`endif
  );
  always #5 clock = ~clock;
  always @(we_n) if (watch && we_n !== 4'hF) wlow++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic rq, input logic [31:0] a, input logic [3:0] w,
                              input logic [3:0] cs, input logic [3:0] wen, input logic st,
                              input logic [31:0] rd, input logic er, input int rdone);
    vec_t x;
    x.req = rq; x.addr = a; x.we = w; x.cs = cs; x.wen = wen; x.st = st;
    x.rd = rd; x.er = er; x.reg_done = rdone;
    return x;
  endfunction
  task automatic apply(input vec_t x, input int n);
    sb_t s;
    req = x.req;
    address = x.addr;
    data_we = x.we;
    data_write = $urandom;
    @(negedge clock);
    chk($sformatf("v%0d cs_n", n), 64'(cs_n), 64'(x.cs));
    chk($sformatf("v%0d we_n", n), 64'(we_n), 64'(x.wen));
    chk($sformatf("v%0d stall", n), 64'(stall), 64'(x.st));
    chk($sformatf("v%0d data_o", n), 64'(data_o), 64'(data_write));
    sbq.push_back('{x.rd, x.er});
    if (x.reg_done >= 0) exp_hits[x.reg_done]++;
    @(posedge clock);
    #1;
    s = sbq.pop_front();
    chk($sformatf("v%0d data_read", n), 64'(data_read), 64'(s.rd));
    chk($sformatf("v%0d err", n), 64'(err), 64'(s.er));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0]  = mk(0, 32'h0000_0000, 4'h0, 4'hF, 4'hF, 0, R0, 0, -1);
    v[1]  = mk(1, 32'h0000_0010, 4'h0, 4'hE, 4'hF, 0, R0, 0, 0);
    v[2]  = mk(1, 32'h4000_0004, 4'h3, 4'hD, 4'hC, 0, R1, 0, 1);
    v[3]  = mk(1, 32'hE000_0000, 4'h0, 4'h7, 4'hF, 1, R1, 0, -1);
    v[4]  = mk(1, 32'hE000_0000, 4'h0, 4'h7, 4'hF, 1, R1, 0, -1);
    v[5]  = mk(1, 32'hE000_0000, 4'h0, 4'h7, 4'hF, 1, R1, 0, -1);
    v[6]  = mk(1, 32'hE000_0000, 4'h0, 4'h7, 4'hF, 0, R3, 0, 3);
    v[7]  = mk(1, 32'h2000_0000, 4'h0, 4'hF, 4'hF, 0, 32'h0, 1, -1);
    v[8]  = mk(0, 32'h0000_0000, 4'h0, 4'hF, 4'hF, 0, 32'h0, 0, -1);
    v[9]  = mk(1, 32'h0000_0000, 4'h0, 4'hE, 4'hF, 0, R0, 0, 0);
    v[10] = mk(1, 32'h4000_0000, 4'h0, 4'hD, 4'hF, 0, R1, 0, 1);
    v[11] = mk(1, 32'h8000_0000, 4'hF, 4'hB, 4'hF, 1, R1, 0, -1);
    v[12] = mk(0, 32'h2000_0000, 4'hF, 4'hB, 4'h0, 0, R2, 0, 2);
    v[13] = mk(1, 32'hE000_0000, 4'hA, 4'h7, 4'hF, 1, R2, 0, -1);
    v[14] = mk(1, 32'hE000_0000, 4'hA, 4'h7, 4'hF, 1, R2, 0, -1);
    v[15] = mk(1, 32'hE000_0000, 4'hA, 4'h7, 4'hF, 1, R2, 0, -1);
    v[16] = mk(1, 32'hE000_0000, 4'hA, 4'h7, 4'h5, 0, R3, 0, 3);
    req = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset cs_n", 64'(cs_n), 64'hF);
    chk("reset we_n", 64'(we_n), 64'hF);
    chk("reset stall", 64'(stall), 64'h0);
    chk("reset err", 64'(err), 64'h0);
    chk("reset data_read", 64'(data_read), 64'(R0));
    #1;
    reset_n = 1'b1;
    req = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 17; i++) apply(v[i], i);
`ifdef MEM_REGION_MUX_PERF_EN
    for (int r = 0; r < 4; r++) chk($sformatf("hit_count%0d", r), 64'(hit_count[16*r +: 16]), 64'(exp_hits[r]));
`endif
    req = 1'b1;
    address = 32'h8000_0000;
    data_we = 4'hF;
    watch = 1'b1;
    @(negedge clock);
    chk("rst_seq stall", 64'(stall), 64'h1);
    chk("rst_seq cs_n", 64'(cs_n), 64'hB);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_seq forced cs_n", 64'(cs_n), 64'hF);
    chk("rst_seq forced stall", 64'(stall), 64'h0);
    chk("rst_seq data_read", 64'(data_read), 64'(R0));
    @(posedge clock);
    @(negedge clock);
    chk("rst_seq held we_n", 64'(we_n), 64'hF);
    req = 1'b0;
    data_we = 4'h0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    req = 1'b1;
    address = 32'h4000_0000;
    @(negedge clock);
    chk("post_rst cs_n", 64'(cs_n), 64'hD);
    chk("post_rst stall", 64'(stall), 64'h0);
    @(posedge clock);
    #1;
    req = 1'b0;
    chk("post_rst data_read", 64'(data_read), 64'(R1));
    watch = 1'b0;
    chk("rst_seq no write", 64'(wlow), 64'h0);
`ifdef MEM_REGION_MUX_PERF_EN
    chk("post_rst hit_count", 64'(hit_count), 64'h0000_0000_0001_0000);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
